// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one 8-bit signed divider among four requesters,
// with divide-by-zero bypass and a RUN timeout that clears a hung divider.
//
// state | meaning
// IDLE  | waiting for any Req_Valid; pick a requester and latch its operands
// ISSUE | acknowledge the requester; bypass on zero divisor, else start divider
// RUN   | divider working; wait for Div_Done or the timeout
// RESP  | present the result for one cycle
// CLR   | second clear cycle for the divider after an abort
module div_arbiter #(
   parameter int TIMEOUT = 32
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [3:0]  Req_Valid,
   input  logic [31:0] Req_Dividend,
   input  logic [31:0] Req_Divisor,
   output logic [3:0]  Req_Ack,
   output logic [3:0]  Rsp_Valid,
   output logic [7:0]  Rsp_Quotient,
   output logic [7:0]  Rsp_Reminder,
   output logic        Rsp_Div0,
   output logic        Rsp_Err,
   output logic        Div_Start,
   output logic [7:0]  Div_Dividend,
   output logic [7:0]  Div_Divisor,
   output logic        Div_Clr,
   input  logic        Div_Done,
   input  logic [7:0]  Div_Quotient,
   input  logic [7:0]  Div_Reminder,
   output logic        Busy,
   output logic [1:0]  Grant_Id
);

   typedef enum logic [2:0] {IDLE, ISSUE, RUN, RESP, CLR} state_t;

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   state_t      state;
   logic [1:0]  rr_ptr;
   logic [1:0]  pick;
   logic [7:0]  tmo_cnt;
   logic        aborted;

   // Scan from the lowest priority up so the highest-priority requester wins last.
   always_comb begin
      pick = rr_ptr;
      for (int i = 3; i >= 0; i--) begin
         if (Req_Valid[rr_ptr + 2'(i)]) pick = rr_ptr + 2'(i);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state        <= IDLE;
         rr_ptr       <= 2'd0;
         tmo_cnt      <= 8'd0;
         aborted      <= 1'b0;
         Req_Ack      <= 4'd0;
         Rsp_Valid    <= 4'd0;
         Rsp_Quotient <= 8'd0;
         Rsp_Reminder <= 8'd0;
         Rsp_Div0     <= 1'b0;
         Rsp_Err      <= 1'b0;
         Div_Start    <= 1'b0;
         Div_Dividend <= 8'd0;
         Div_Divisor  <= 8'd0;
         Div_Clr      <= 1'b1;
         Busy         <= 1'b0;
         Grant_Id     <= 2'd0;
      end else begin
         Req_Ack   <= 4'd0;
         Rsp_Valid <= 4'd0;
         Div_Clr   <= 1'b0;
         case (state)
            IDLE: begin
               if (|Req_Valid) begin
                  Grant_Id      <= pick;
                  rr_ptr        <= pick + 2'd1;
                  Div_Dividend  <= Req_Dividend[{pick, 3'b000} +: 8];
                  Div_Divisor   <= Req_Divisor[{pick, 3'b000} +: 8];
                  Req_Ack[pick] <= 1'b1;
                  Busy          <= 1'b1;
                  state         <= ISSUE;
               end
            end
            ISSUE: begin
               if (Div_Divisor == 8'd0) begin
                  Rsp_Valid[Grant_Id] <= 1'b1;
                  Rsp_Div0            <= 1'b1;
                  Rsp_Err             <= 1'b0;
                  Rsp_Quotient        <= 8'hFF;
                  // -128 negates to itself, which is the wanted 8'h80 magnitude.
                  Rsp_Reminder        <= Div_Dividend[7] ? (8'd0 - Div_Dividend) : Div_Dividend;
                  aborted             <= 1'b0;
                  state               <= RESP;
               end else begin
                  Div_Start <= 1'b1;
                  tmo_cnt   <= 8'd0;
                  state     <= RUN;
               end
            end
            RUN: begin
               if (Div_Done) begin
                  Div_Start           <= 1'b0;
                  Rsp_Valid[Grant_Id] <= 1'b1;
                  Rsp_Quotient        <= Div_Quotient;
                  Rsp_Reminder        <= Div_Reminder;
                  Rsp_Div0            <= 1'b0;
                  Rsp_Err             <= 1'b0;
                  aborted             <= 1'b0;
                  state               <= RESP;
               end else if (tmo_cnt == TMO_LAST) begin
                  Div_Start           <= 1'b0;
                  Div_Clr             <= 1'b1;
                  Rsp_Valid[Grant_Id] <= 1'b1;
                  Rsp_Quotient        <= 8'd0;
                  Rsp_Reminder        <= 8'd0;
                  Rsp_Div0            <= 1'b0;
                  Rsp_Err             <= 1'b1;
                  aborted             <= 1'b1;
                  state               <= RESP;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
            end
            RESP: begin
               if (aborted) begin
                  Div_Clr <= 1'b1;
                  state   <= CLR;
               end else begin
                  Busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            CLR: begin
               Busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               Busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter: behavioural 10-cycle divider plus a
// scoreboard of expected responses, pushed at request time and popped on Rsp_Valid.
module tb_div_arbiter;

   localparam int TIMEOUT = 32;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [3:0]  Req_Valid = 4'd0;
   logic [31:0] Req_Dividend = 32'd0;
   logic [31:0] Req_Divisor = 32'd0;
   logic [3:0]  Req_Ack;
   logic [3:0]  Rsp_Valid;
   logic [7:0]  Rsp_Quotient;
   logic [7:0]  Rsp_Reminder;
   logic        Rsp_Div0;
   logic        Rsp_Err;
   logic        Div_Start;
   logic [7:0]  Div_Dividend;
   logic [7:0]  Div_Divisor;
   logic        Div_Clr;
   logic        Div_Done = 1'b0;
   logic [7:0]  Div_Quotient = 8'd0;
   logic [7:0]  Div_Reminder = 8'd0;
   logic        Busy;
   logic [1:0]  Grant_Id;

   div_arbiter #(.TIMEOUT(TIMEOUT)) dut (
      .CLK(CLK), .RST(RST),
      .Req_Valid(Req_Valid), .Req_Dividend(Req_Dividend), .Req_Divisor(Req_Divisor),
      .Req_Ack(Req_Ack), .Rsp_Valid(Rsp_Valid), .Rsp_Quotient(Rsp_Quotient),
      .Rsp_Reminder(Rsp_Reminder), .Rsp_Div0(Rsp_Div0), .Rsp_Err(Rsp_Err),
      .Div_Start(Div_Start), .Div_Dividend(Div_Dividend), .Div_Divisor(Div_Divisor),
      .Div_Clr(Div_Clr), .Div_Done(Div_Done), .Div_Quotient(Div_Quotient),
      .Div_Reminder(Div_Reminder), .Busy(Busy), .Grant_Id(Grant_Id)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
   endtask

   typedef struct {
      logic [1:0] id;
      logic [7:0] q;
      logic [7:0] r;
      logic       div0;
      logic       err;
   } exp_t;

   exp_t sb[$];

   function automatic logic [7:0] q8(input int a, input int b);
      return (b == 0) ? 8'h00 : 8'(a / b);
   endfunction

   function automatic logic [7:0] r8(input int a, input int b);
      int r;
      if (b == 0) return 8'h00;
      r = a % b;
      return 8'(r < 0 ? -r : r);
   endfunction

   function automatic exp_t mk_exp(input int id, input int a, input int b, input bit tmo);
      exp_t e;
      e.id   = 2'(id);
      e.err  = tmo;
      e.div0 = 1'b0;
      if (tmo) begin
         e.q = 8'h00;
         e.r = 8'h00;
      end else if (b == 0) begin
         e.q    = 8'hFF;
         e.r    = 8'(a < 0 ? -a : a);
         e.div0 = 1'b1;
      end else begin
         e.q = q8(a, b);
         e.r = r8(a, b);
      end
      return e;
   endfunction

   function automatic int onehot_idx(input logic [3:0] v);
      for (int i = 0; i < 4; i++) if (v[i]) return i;
      return -1;
   endfunction

   // Divider: Div_Done pulses 10 cycles after Div_Start rises; stub mode never finishes.
   bit stub = 1'b0;
   int dcnt = 0;
   always @(posedge CLK) begin
      Div_Done <= 1'b0;
      if (RST || Div_Clr) begin
         dcnt <= 0;
      end else if (Div_Start && !Div_Done) begin
         if (dcnt == 9 && !stub) begin
            Div_Done     <= 1'b1;
            Div_Quotient <= q8($signed(Div_Dividend), $signed(Div_Divisor));
            Div_Reminder <= r8($signed(Div_Dividend), $signed(Div_Divisor));
            dcnt         <= 0;
         end else begin
            dcnt <= dcnt + 1;
         end
      end else begin
         dcnt <= 0;
      end
   end

   int ack_cyc  = 0;
   int last_rsp = -1;
   bit gap_chk  = 1'b0;

   always @(negedge CLK) begin
      exp_t e;
      int   lat;
      if (Req_Ack != 4'd0) begin
         if (sb.size() == 0) begin
            chk("ack_pending", 32'(Req_Ack), 32'd0);
         end else begin
            chk("ack_onehot", $countones(Req_Ack), 32'd1);
            chk("ack_id", onehot_idx(Req_Ack), 32'(sb[0].id));
            chk("grant_id", 32'(Grant_Id), 32'(sb[0].id));
            chk("busy_issue", 32'(Busy), 32'd1);
            if (gap_chk && last_rsp >= 0) chk("idle_gap", cyc - last_rsp, 32'd2);
         end
         ack_cyc = cyc;
      end
      if (Rsp_Valid != 4'd0) begin
         if (sb.size() == 0) begin
            chk("rsp_unexpected", 32'(Rsp_Valid), 32'd0);
         end else begin
            e   = sb.pop_front();
            lat = cyc - ack_cyc;
            chk("rsp_onehot", $countones(Rsp_Valid), 32'd1);
            chk("rsp_id", onehot_idx(Rsp_Valid), 32'(e.id));
            chk("rsp_q", 32'(Rsp_Quotient), 32'(e.q));
            chk("rsp_r", 32'(Rsp_Reminder), 32'(e.r));
            chk("rsp_div0", 32'(Rsp_Div0), 32'(e.div0));
            chk("rsp_err", 32'(Rsp_Err), 32'(e.err));
            if (e.err) chk("lat_tmo", 32'(lat >= TIMEOUT + 1 && lat <= TIMEOUT + 2), 32'd1);
            else       chk("lat_rsp", lat, e.div0 ? 32'd1 : 32'd12);
         end
         last_rsp = cyc;
      end
   end

   bit watch_start = 1'b0;
   bit start_seen  = 1'b0;
   always @(negedge CLK) if (watch_start && Div_Start) start_seen = 1'b1;

   task automatic send(input int k, input int a, input int b, input bit tmo);
      int n;
      @(negedge CLK);
      Req_Dividend[8*k +: 8] = 8'(a);
      Req_Divisor[8*k +: 8]  = 8'(b);
      Req_Valid[k]           = 1'b1;
      sb.push_back(mk_exp(k, a, b, tmo));
      n = 0;
      do begin
         @(negedge CLK);
         n++;
      end while (!Req_Ack[k] && n < 20);
      chk("ack_latency", n, 32'd1);
      Req_Valid[k] = 1'b0;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while ((sb.size() != 0 || Busy) && n < 200) begin
         @(negedge CLK);
         n++;
      end
      chk("drain_bound", 32'(n < 200), 32'd1);
   endtask

   task automatic fairness();
      int da[4] = '{100, -100, 127, -128};
      int db[4] = '{7, 9, -3, 5};
      int n_ack;
      int n;
      @(negedge CLK);
      last_rsp = -1;
      gap_chk  = 1'b1;
      for (int i = 0; i < 8; i++) sb.push_back(mk_exp(i % 4, da[i % 4], db[i % 4], 1'b0));
      for (int k = 0; k < 4; k++) begin
         Req_Dividend[8*k +: 8] = 8'(da[k]);
         Req_Divisor[8*k +: 8]  = 8'(db[k]);
      end
      Req_Valid = 4'hF;
      n_ack = 0;
      n = 0;
      while (n_ack < 8 && n < 400) begin
         @(negedge CLK);
         n++;
         if (Req_Ack != 4'd0) n_ack++;
      end
      Req_Valid = 4'd0;
      chk("fair_acks", n_ack, 32'd8);
      wait_done();
      gap_chk = 1'b0;
   endtask

   initial begin
      int n;
      repeat (3) @(negedge CLK);
      chk("rst_outputs", 32'(|{Req_Ack, Rsp_Valid, Rsp_Quotient, Rsp_Reminder, Rsp_Div0, Rsp_Err,
                               Div_Start, Div_Dividend, Div_Divisor, Busy, Grant_Id}), 32'd0);
      chk("rst_div_clr", 32'(Div_Clr), 32'd1);
      RST = 1'b0;
      @(negedge CLK);
      chk("div_clr_release", 32'(Div_Clr), 32'd0);
      chk("idle_busy", 32'(Busy), 32'd0);

      send(0, 100, 7, 1'b0);
      wait_done();
      send(2, -7, 2, 1'b0);
      wait_done();

      start_seen  = 1'b0;
      watch_start = 1'b1;
      send(1, -5, 0, 1'b0);
      wait_done();
      watch_start = 1'b0;
      chk("div0_no_start", 32'(start_seen), 32'd0);

      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
      fairness();

      stub = 1'b1;
      send(3, 50, 5, 1'b1);
      n = 0;
      while (!Rsp_Valid[3] && n < TIMEOUT + 20) begin
         @(negedge CLK);
         n++;
      end
      chk("tmo_clr_0", 32'(Div_Clr), 32'd1);
      chk("tmo_start_low", 32'(Div_Start), 32'd0);
      @(negedge CLK);
      chk("tmo_clr_1", 32'(Div_Clr), 32'd1);
      @(negedge CLK);
      chk("tmo_clr_2", 32'(Div_Clr), 32'd0);
      stub = 1'b0;
      wait_done();
      send(0, 100, 7, 1'b0);
      wait_done();

      send(2, 60, 4, 1'b0);
      repeat (5) @(negedge CLK);
      chk("run_before_rst", 32'(Div_Start), 32'd1);
      RST = 1'b1;
      @(negedge CLK);
      sb.delete();
      chk("midrun_outputs", 32'(|{Req_Ack, Rsp_Valid, Rsp_Quotient, Rsp_Reminder, Rsp_Div0, Rsp_Err,
                                  Div_Start, Div_Dividend, Div_Divisor, Busy, Grant_Id}), 32'd0);
      chk("midrun_div_clr", 32'(Div_Clr), 32'd1);
      RST = 1'b0;
      @(negedge CLK);
      chk("midrun_clr_release", 32'(Div_Clr), 32'd0);
      repeat (15) @(negedge CLK);
      send(1, -20, 3, 1'b0);
      wait_done();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/div_arbiter.md
DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 Parameter: TIMEOUT, 32, maximum number of RUN cycles to wait for Div_Done before aborting (legal range 12..255).
REQ-002 CLK  in  1  single clock; all logic is rising-edge.
REQ-003 RST  in  1  reset, synchronous, active-high.
REQ-004 Req_Valid  in  4  per-requester request; held high until the matching Req_Ack.
REQ-005 Req_Dividend  in  32  four packed signed 8-bit dividends; requester k uses bits [8k+7:8k].
REQ-006 Req_Divisor  in  32  four packed signed 8-bit divisors; same packing.
REQ-007 Req_Ack  out  4  one-hot, one-cycle pulse; operands of requester k captured.
REQ-008 Rsp_Valid  out  4  one-hot, one-cycle pulse; result for requester k is on the Rsp_* buses.
REQ-009 Rsp_Quotient  out  8  signed quotient, valid with Rsp_Valid.
REQ-010 Rsp_Reminder  out  8  remainder magnitude, valid with Rsp_Valid.
REQ-011 Rsp_Div0  out  1  divisor was zero, valid with Rsp_Valid.
REQ-012 Rsp_Err  out  1  timeout abort, valid with Rsp_Valid.
REQ-013 Div_Start  out  1  level start to the shared 8-bit divider.
REQ-014 Div_Dividend / Div_Divisor  out  8 each  operands to the divider; stable while Div_Start is high.
REQ-015 Div_Clr  out  1  active-high clear to the divider, wired by the integrator to the divider reset.
REQ-016 Div_Done  in  1  divider completion pulse.
REQ-017 Div_Quotient / Div_Reminder  in  8 each  divider results, sampled when Div_Done is high.
REQ-018 Busy  out  1  high in any state other than IDLE.
REQ-019 Grant_Id  out  2  index of the requester currently served; holds its last value in IDLE.

Function
REQ-020 FSM states: IDLE, ISSUE, RUN, RESP, CLR; all outputs are registered.
REQ-021 IDLE: if any Req_Valid bit is high, select a requester k by round-robin and capture its operands into Div_Dividend/Div_Divisor; set Grant_Id=k; go to ISSUE.
REQ-022 Round-robin: after reset, priority order is 0,1,2,3; after requester k is granted, the highest priority becomes (k+1) mod 4.
REQ-023 ISSUE: Req_Ack[k]=1 for exactly this cycle; divisor==0 -> RESP with Rsp_Div0=1, Rsp_Quotient=8'hFF, Rsp_Reminder=|dividend| (8'h80 for -128), divider not started; otherwise Div_Start<=1, timeout counter<=0, go to RUN.
REQ-024 RUN: Div_Start stays high; the counter increments every cycle.
REQ-025 RUN, Div_Done sampled high: Div_Start<=0 on that edge; capture Div_Quotient/Div_Reminder into the Rsp buses; go to RESP.
REQ-026 RUN, counter reaches TIMEOUT with no Div_Done: Div_Start<=0; Rsp_Quotient=0; Rsp_Reminder=0; Rsp_Err=1; Div_Clr=1 for one cycle; go to RESP.
REQ-027 If Div_Done and the timeout occur in the same cycle, Div_Done wins: normal response, Rsp_Err=0.
REQ-028 RESP: Rsp_Valid[k]=1 for one cycle; Rsp_* flags and values are held until the next RESP; next state is CLR if an abort occurred, else IDLE.
REQ-029 CLR: Div_Clr=1 for one cycle (the divider is held clear for two cycles in total after an abort); go to IDLE.
REQ-030 Div_Start is never high in the cycle following a sampled Div_Done, so the divider cannot restart.
REQ-031 Req_Valid of the requester being served, and all Req_Valid bits outside IDLE, are ignored; a request is considered only in IDLE.
REQ-032 Sustained load: back-to-back grants occur with exactly one IDLE cycle between a RESP and the next ISSUE.
REQ-033 Div_Done while not in RUN: ignored, no state change.
REQ-034 Latency with the team divider (10 cycles from Div_Start rise to Div_Done): Req_Valid sampled in cycle T -> Req_Ack in T+1, Div_Start in T+2..T+12, Rsp_Valid in T+13; divide-by-zero case: Rsp_Valid in T+2.

Reset
REQ-035 While RST is high, all of the following are 0: Req_Ack, Rsp_Valid, Rsp_Quotient, Rsp_Reminder, Rsp_Div0, Rsp_Err, Div_Start, Div_Dividend, Div_Divisor, Busy, Grant_Id; round-robin pointer -> requester 0; state -> IDLE.
REQ-036 Div_Clr resets to 1 and drops to 0 on the first edge with RST low, so the divider is always cleared with the controller.
REQ-037 RST asserted mid-RUN: the in-flight transaction is dropped with no Rsp_Valid; Div_Start is low on the next edge.

Verification
REQ-038 Single request: Req_Valid=4'b0001, dividend 100, divisor 7 -> Req_Ack[0] at T+1, Rsp_Valid[0] at T+13, Q=8'h0E, R=8'h02, Rsp_Div0=0, Rsp_Err=0.
REQ-039 Signed case: requester 2, dividend -7 (8'hF9), divisor 2 -> Q=8'hFD, R=8'h01, Grant_Id=2.
REQ-040 Fairness: all four Req_Valid held high for 8 transactions -> grant order 0,1,2,3,0,1,2,3 with one IDLE cycle between a RESP and the next ISSUE.
REQ-041 Divide-by-zero: requester 1, dividend -5, divisor 0 -> Rsp_Valid[1] at T+2, Q=8'hFF, R=8'h05, Rsp_Div0=1, Div_Start never high.
REQ-042 Timeout: stub divider with Div_Done never asserted, TIMEOUT=32 -> Rsp_Err=1, Q=0, R=0, Div_Clr high for two cycles, then the next request completes normally.
REQ-043 Reset mid-RUN: RST high at T+6 for one cycle -> no Rsp_Valid; all outputs at reset values; Div_Clr=1 until RST falls; a new request completes in 13 cycles.
